alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_arbiter_if.sv | 35 +++
 rtl/alu_arbiter_alu.sv | 37 +++
 rtl/alu_arbiter.sv | 103 ++++++++++
 tb/tb_alu_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encodings and request record for the two-port ALU arbiter.
package alu_pkg;

  localparam int MULT_LATENCY_DEF = 3;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_MULT = 4'b1001;
  localparam logic [3:0] OP_EQ0  = 4'b1110;
  localparam logic [3:0] OP_SLT  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arbState_e;

  typedef struct packed {
    logic        id;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } aluReq_t;

  // Opcodes 1010..1101 have no ALU function and are reported as errors.
  function automatic logic isUnassigned(input logic [3:0] op);
    return (op >= 4'b1010) && (op <= 4'b1101);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Two requester channels plus one response channel; master drives requests, slave is the arbiter.
interface alu_arbiter_if;
  logic        req0Valid;
  logic        req0Ready;
  logic [3:0]  req0Op;
  logic [15:0] req0A;
  logic [15:0] req0B;
  logic        req1Valid;
  logic        req1Ready;
  logic [3:0]  req1Op;
  logic [15:0] req1A;
  logic [15:0] req1B;
  logic        rspValid;
  logic        rspReady;
  logic        rspId;
  logic [15:0] rspResult;
  logic        rspZero;
  logic        rspErr;

  modport master (
    output req0Valid, req0Op, req0A, req0B,
    output req1Valid, req1Op, req1A, req1B,
    output rspReady,
    input  req0Ready, req1Ready,
    input  rspValid, rspId, rspResult, rspZero, rspErr
  );

  modport slave (
    input  req0Valid, req0Op, req0A, req0B,
    input  req1Valid, req1Op, req1A, req1B,
    input  rspReady,
    output req0Ready, req1Ready,
    output rspValid, rspId, rspResult, rspZero, rspErr
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// ALU16bit: combinational 16-bit ALU, wrap-around arithmetic, active-high rst forces result to 0.
// Unassigned opcodes yield result 0 (so isZero=1).
module ALU16bit
  import alu_pkg::*;
(
  input  logic        rst,
  input  logic [3:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        isZero
);

  always_comb begin
    result = 16'd0;
    if (!rst) begin
      case (op)
        OP_ADD:  result = a + b;
        OP_OR:   result = a | b;
        OP_XOR:  result = a ^ b;
        OP_AND:  result = a & b;
        OP_NOR:  result = ~(a | b);
        OP_SLL:  result = a << b[3:0];
        OP_SRL:  result = a >> b[3:0];
        OP_SUB:  result = a - b;
        OP_NAND: result = ~(a & b);
        OP_MULT: result = a * b;
        OP_EQ0:  result = {15'd0, (a == 16'd0)};
        OP_SLT:  result = {15'd0, ($signed(a) < $signed(b))};
        default: result = 16'd0;
      endcase
    end
  end

  assign isZero = (result == 16'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU16bit between two requesters; 1 EXEC cycle (MULT: MULT_LATENCY).
// One op in flight: requesters see ready only in IDLE; the response holds until rspReady.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int MULT_LATENCY = MULT_LATENCY_DEF
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] MULT_CNT_LOAD = 4'(MULT_LATENCY - 1);

  arbState_e   state;
  arbState_e   stateNext;
  aluReq_t     held;
  aluReq_t     incoming;
  logic [3:0]  cnt;
  logic        prio;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic [15:0] aluResult;
  logic        aluZero;
  logic        rspIdReg;
  logic [15:0] rspResultReg;
  logic        rspZeroReg;
  logic        rspErrReg;

  assign grant0 = bus.req0Valid && (!bus.req1Valid || !prio);
  assign grant1 = bus.req1Valid && (!bus.req0Valid || prio);

  // Gated by reset so readiness drops immediately, not at the next edge.
  assign bus.req0Ready = reset && (state == IDLE) && grant0;
  assign bus.req1Ready = reset && (state == IDLE) && grant1;
  assign accept        = bus.req0Ready || bus.req1Ready;

  always_comb begin
    incoming.id = bus.req1Ready;
    incoming.op = bus.req1Ready ? bus.req1Op : bus.req0Op;
    incoming.a  = bus.req1Ready ? bus.req1A  : bus.req0A;
    incoming.b  = bus.req1Ready ? bus.req1B  : bus.req0B;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = EXEC;
      EXEC:    if (cnt == 4'd0) stateNext = RESP;
      RESP:    if (bus.rspReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held         <= '0;
      cnt          <= 4'd0;
      prio         <= 1'b0;
      rspIdReg     <= 1'b0;
      rspResultReg <= 16'd0;
      rspZeroReg   <= 1'b0;
      rspErrReg    <= 1'b0;
    end else begin
      if (accept) begin
        held <= incoming;
        prio <= ~incoming.id;
        cnt  <= (incoming.op == OP_MULT) ? MULT_CNT_LOAD : 4'd0;
      end else if ((state == EXEC) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if ((state == EXEC) && (cnt == 4'd0)) begin
        rspIdReg     <= held.id;
        rspResultReg <= aluResult;
        rspZeroReg   <= aluZero;
        rspErrReg    <= isUnassigned(held.op);
      end
    end
  end

  // ALU sees only latched operands, so request ports may change freely after accept.
  ALU16bit u_alu (
    .rst    (!reset),
    .op     (held.op),
    .a      (held.a),
    .b      (held.b),
    .result (aluResult),
    .isZero (aluZero)
  );

  assign bus.rspValid  = (state == RESP);
  assign bus.rspId     = rspIdReg;
  assign bus.rspResult = rspResultReg;
  assign bus.rspZero   = rspZeroReg;
  assign bus.rspErr    = rspErrReg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scenario bench for alu_arbiter: expected responses queued at issue time, popped on rspValid.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  alu_arbiter_if busIf();

  alu_arbiter #(.MULT_LATENCY(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] rspWord();
    return {busIf.rspId, busIf.rspResult, busIf.rspZero, busIf.rspErr};
  endfunction

  function automatic logic [18:0] expWord(input exp_t e);
    return {e.id, e.res, e.zero, e.err};
  endfunction

  function automatic exp_t mkExp(input logic id, input logic [15:0] res, input logic zero,
                                 input logic err);
    exp_t e;
    e.id = id; e.res = res; e.zero = zero; e.err = err;
    return e;
  endfunction

  // Independent reference for the random phase.
  function automatic exp_t model(input logic id, input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b);
    logic [15:0] r;
    logic [3:0]  sh;
    sh = b[3:0];
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a | b;
      4'd2:  r = a ^ b;
      4'd3:  r = a & b;
      4'd4:  r = ~(a | b);
      4'd5:  r = a << sh;
      4'd6:  r = a >> sh;
      4'd7:  r = a - b;
      4'd8:  r = ~(a & b);
      4'd9:  r = a * b;
      4'd14: r = (a == 16'd0) ? 16'd1 : 16'd0;
      4'd15: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      default: r = 16'd0;
    endcase
    return mkExp(id, r, (r == 16'd0), (op >= 4'd10) && (op <= 4'd13));
  endfunction

  task automatic drive(input logic id, input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    if (id) begin
      busIf.req1Valid = v; busIf.req1Op = op; busIf.req1A = a; busIf.req1B = b;
    end else begin
      busIf.req0Valid = v; busIf.req0Op = op; busIf.req0A = a; busIf.req0B = b;
    end
  endtask

  // Returns with the accepting edge just behind us; ok=0 if never granted.
  task automatic issue(input logic id, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, output bit ok);
    ok = 1'b0;
    drive(id, 1'b1, op, a, b);
    #1;
    for (int i = 0; i < 40; i++) begin
      if (id ? busIf.req1Ready : busIf.req0Ready) begin
        ok = 1'b1;
        break;
      end
      tick();
      #1;
    end
    if (ok) tick();
    drive(id, 1'b0, op, a, b);
  endtask

  task automatic waitRsp(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 40; i++) begin
      if (busIf.rspValid) begin
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    busIf.rspReady = 1'b1;
    drive(1'b0, 1'b1, OP_ADD, 16'd1, 16'd2);
    drive(1'b1, 1'b1, OP_ADD, 16'd3, 16'd4);
    #3;
    total++;
    if ({busIf.rspValid, busIf.req0Ready, busIf.req1Ready, rspWord()} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b r0=%b r1=%b word=%h want all zero",
               busIf.rspValid, busIf.req0Ready, busIf.req1Ready, rspWord());
    end
    drive(1'b0, 1'b0, OP_ADD, 16'd0, 16'd0);
    drive(1'b1, 1'b0, OP_ADD, 16'd0, 16'd0);
    #19 reset = 1'b1;
    tick();
  endtask

  task automatic test_add;
    exp_t e;
    bit ok;
    int n;
    sbq.push_back(mkExp(1'b0, 16'd37, 1'b0, 1'b0));
    drive(1'b0, 1'b1, OP_ADD, 16'd13, 16'd24);
    #1;
    total++;
    if (busIf.req0Ready !== 1'b1) begin
      bad++;
      $display("FAIL add_ready: got %b want 1", busIf.req0Ready);
    end
    tick();
    drive(1'b0, 1'b0, OP_ADD, 16'd0, 16'd0);
    waitRsp(ok, n);
    total++;
    if (!ok || n != 1) begin
      bad++;
      $display("FAIL add_latency: got ok=%0d cycles=%0d want ok=1 cycles=1", ok, n);
    end
    e = sbq.pop_front();
    total++;
    if (rspWord() !== expWord(e)) begin
      bad++;
      $display("FAIL add_rsp: got %h want %h", rspWord(), expWord(e));
    end
    tick();
    total++;
    if (busIf.rspValid !== 1'b0) begin
      bad++;
      $display("FAIL add_release: rspValid got %b want 0", busIf.rspValid);
    end
  endtask

  task automatic test_priority;
    exp_t e;
    bit ok;
    int n;
    #2 reset = 1'b0;
    #5 reset = 1'b1;
    tick();
    busIf.rspReady = 1'b1;
    drive(1'b0, 1'b1, OP_SUB, 16'h4000, 16'h3FFF);
    drive(1'b1, 1'b1, OP_NAND, 16'hAAAA, 16'hAAAA);
    sbq.push_back(mkExp(1'b0, 16'h0001, 1'b0, 1'b0));
    sbq.push_back(mkExp(1'b1, 16'h5555, 1'b0, 1'b0));
    #1;
    total++;
    if ({busIf.req0Ready, busIf.req1Ready} !== 2'b10) begin
      bad++;
      $display("FAIL prio_grant: got r0=%b r1=%b want r0=1 r1=0", busIf.req0Ready, busIf.req1Ready);
    end
    tick();
    drive(1'b0, 1'b0, OP_SUB, 16'd0, 16'd0);
    for (int k = 0; k < 2; k++) begin
      waitRsp(ok, n);
      e = sbq.pop_front();
      total++;
      if (!ok || rspWord() !== expWord(e)) begin
        bad++;
        $display("FAIL prio_rsp%0d: got ok=%0d %h want %h", k, ok, rspWord(), expWord(e));
      end
      tick();
      if (k == 0) begin
        total++;
        if (busIf.req1Ready !== 1'b1) begin
          bad++;
          $display("FAIL prio_second_ready: got %b want 1", busIf.req1Ready);
        end
        tick();
        drive(1'b1, 1'b0, OP_NAND, 16'd0, 16'd0);
      end
    end
  endtask

  task automatic test_mult;
    exp_t e;
    int stray;
    sbq.push_back(mkExp(1'b1, 16'h0033, 1'b0, 1'b0));
    drive(1'b1, 1'b1, OP_MULT, 16'd3, 16'h0011);
    #1;
    total++;
    if (busIf.req1Ready !== 1'b1) begin
      bad++;
      $display("FAIL mult_ready: got %b want 1", busIf.req1Ready);
    end
    tick();
    drive(1'b1, 1'b0, OP_ADD, 16'hFFFF, 16'hFFFF);
    drive(1'b0, 1'b1, OP_ADD, 16'd1, 16'd1);
    stray = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (busIf.rspValid || busIf.req0Ready || busIf.req1Ready) stray++;
      if (c == 2) drive(1'b0, 1'b0, OP_ADD, 16'd0, 16'd0);
      tick();
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL mult_exec_quiet: got %0d busy cycles with ready/valid want 0", stray);
    end
    total++;
    if (busIf.rspValid !== 1'b1) begin
      bad++;
      $display("FAIL mult_latency: rspValid got %b want 1 at accept+3", busIf.rspValid);
    end
    e = sbq.pop_front();
    total++;
    if (rspWord() !== expWord(e)) begin
      bad++;
      $display("FAIL mult_rsp: got %h want %h", rspWord(), expWord(e));
    end
    tick();
  endtask

  task automatic test_back_pressure;
    exp_t e;
    bit ok;
    int n;
    int held;
    busIf.rspReady = 1'b0;
    sbq.push_back(mkExp(1'b0, 16'h8000, 1'b0, 1'b0));
    sbq.push_back(mkExp(1'b1, 16'd11, 1'b0, 1'b0));
    issue(1'b0, OP_SLL, 16'h0001, 16'd15, ok);
    drive(1'b1, 1'b1, OP_ADD, 16'd5, 16'd6);
    tick();
    held = 0;
    for (int c = 0; c < 5; c++) begin
      if (busIf.rspValid === 1'b1 && rspWord() === expWord(sbq[0]) && busIf.req1Ready === 1'b0)
        held++;
      tick();
    end
    total++;
    if (!ok || held != 5) begin
      bad++;
      $display("FAIL stall_hold: got issued=%0d stable_cycles=%0d want issued=1 stable_cycles=5",
               ok, held);
    end
    busIf.rspReady = 1'b1;
    #1;
    e = sbq.pop_front();
    total++;
    if (busIf.rspValid !== 1'b1 || rspWord() !== expWord(e)) begin
      bad++;
      $display("FAIL stall_rsp: got v=%b %h want v=1 %h", busIf.rspValid, rspWord(), expWord(e));
    end
    tick();
    total++;
    if (busIf.req1Ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_next_ready: got %b want 1", busIf.req1Ready);
    end
    tick();
    drive(1'b1, 1'b0, OP_ADD, 16'd0, 16'd0);
    waitRsp(ok, n);
    e = sbq.pop_front();
    total++;
    if (!ok || rspWord() !== expWord(e)) begin
      bad++;
      $display("FAIL stall_followup: got ok=%0d %h want %h", ok, rspWord(), expWord(e));
    end
    tick();
  endtask

  task automatic test_err_eq0;
    exp_t e;
    bit ok;
    bit okr;
    int n;
    sbq.push_back(mkExp(1'b0, 16'd0, 1'b1, 1'b1));
    issue(1'b0, 4'b1011, 16'd5, 16'd7, ok);
    waitRsp(okr, n);
    e = sbq.pop_front();
    total++;
    if (!ok || !okr || n != 1 || rspWord() !== expWord(e)) begin
      bad++;
      $display("FAIL err_op: got cycles=%0d %h want cycles=1 %h", n, rspWord(), expWord(e));
    end
    tick();
    sbq.push_back(mkExp(1'b1, 16'd1, 1'b0, 1'b0));
    issue(1'b1, OP_EQ0, 16'd0, 16'd9, ok);
    waitRsp(okr, n);
    e = sbq.pop_front();
    total++;
    if (!ok || !okr || rspWord() !== expWord(e)) begin
      bad++;
      $display("FAIL eq0: got %h want %h", rspWord(), expWord(e));
    end
    tick();
  endtask

  task automatic test_reset_mid_mult;
    exp_t e;
    bit ok;
    int n;
    int stray;
    issue(1'b0, OP_MULT, 16'd7, 16'd9, ok);
    tick();
    #2 reset = 1'b0;
    drive(1'b0, 1'b1, OP_ADD, 16'd1, 16'd1);
    drive(1'b1, 1'b1, OP_ADD, 16'd1, 16'd1);
    #1;
    total++;
    if (!ok || {busIf.rspValid, busIf.req0Ready, busIf.req1Ready, rspWord()} !== 22'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got v=%b r0=%b r1=%b word=%h want all zero",
               busIf.rspValid, busIf.req0Ready, busIf.req1Ready, rspWord());
    end
    drive(1'b0, 1'b0, OP_ADD, 16'd0, 16'd0);
    drive(1'b1, 1'b0, OP_ADD, 16'd0, 16'd0);
    tick();
    tick();
    #2 reset = 1'b1;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (busIf.rspValid !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL midreset_no_rsp: got %0d cycles with rspValid want 0", stray);
    end
    drive(1'b0, 1'b1, OP_XOR, 16'h00FF, 16'h0F0F);
    drive(1'b1, 1'b1, OP_OR, 16'h1200, 16'h0034);
    sbq.push_back(mkExp(1'b0, 16'h0FF0, 1'b0, 1'b0));
    sbq.push_back(mkExp(1'b1, 16'h1234, 1'b0, 1'b0));
    #1;
    total++;
    if ({busIf.req0Ready, busIf.req1Ready} !== 2'b10) begin
      bad++;
      $display("FAIL midreset_prio: got r0=%b r1=%b want r0=1 r1=0", busIf.req0Ready, busIf.req1Ready);
    end
    tick();
    drive(1'b0, 1'b0, OP_XOR, 16'd0, 16'd0);
    for (int k = 0; k < 2; k++) begin
      waitRsp(ok, n);
      e = sbq.pop_front();
      total++;
      if (!ok || rspWord() !== expWord(e)) begin
        bad++;
        $display("FAIL midreset_rsp%0d: got ok=%0d %h want %h", k, ok, rspWord(), expWord(e));
      end
      tick();
      if (k == 0) begin
        tick();
        drive(1'b1, 1'b0, OP_OR, 16'd0, 16'd0);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit ok;
    bit okr;
    int n;
    logic id;
    logic [3:0] op;
    logic [15:0] a;
    logic [15:0] b;
    for (int k = 0; k < 24; k++) begin
      id = 1'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (k % 4 == 0) a = 16'd0;
      sbq.push_back(model(id, op, a, b));
      issue(id, op, a, b, ok);
      waitRsp(okr, n);
      e = sbq.pop_front();
      total++;
      if (!ok || !okr || n != ((op == OP_MULT) ? 3 : 1) || rspWord() !== expWord(e)) begin
        bad++;
        $display("FAIL b2b_%0d op=%h a=%h b=%h: got cycles=%0d %h want cycles=%0d %h", k, op, a, b,
                 n, rspWord(), (op == OP_MULT) ? 3 : 1, expWord(e));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_priority();
    test_mult();
    test_back_pressure();
    test_err_eq0();
    test_reset_mid_mult();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
